// File: rtl/booth_seq_mult_ctrl_pkg.sv
// Package for the sequential radix-2 Booth multiplier controller.
// Holds the FSM state encoding, the Booth operation codes, the default
// operand width and the Booth pair decoder shared by the controller.
package booth_seq_mult_ctrl_pkg;

  localparam int DEFAULT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_ADD = 2'd1,
    OP_SUB = 2'd2
  } booth_op_t;

  // Radix-2 Booth recoding of the {Q[0], q_1} bit pair.
  function automatic booth_op_t booth_decode(input logic q0, input logic q_1);
    booth_op_t op;
    case ({q0, q_1})
      2'b01:   op = OP_ADD;
      2'b10:   op = OP_SUB;
      default: op = OP_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_seq_mult_ctrl_if.sv
// Operand/result handshake between the operand registers (master) and the
// Booth sequencer (slave).
//   start   : request, sampled by the slave only when it is ready
//   a, b    : signed multiplicand / multiplier, captured on accepted start
//   busy    : slave is running Booth steps
//   done    : one-cycle pulse, product valid
//   product : signed a*b, held until the next accepted operation completes
interface booth_seq_mult_ctrl_if #(
  parameter int W = 8
);
  logic             start;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             busy;
  logic             done;
  logic [2*W-1:0]   product;

  modport master (output start, output a, output b,
                  input busy, input done, input product);
  modport slave  (input start, input a, input b,
                  output busy, output done, output product);
endinterface

// File: rtl/booth_seq_mult_ctrl_addsub.sv
// rca_addsub: N-bit ripple-carry adder/subtractor built from full-adder cells.
//   x, y : operands
//   sub  : 0 -> s = x + y, 1 -> s = x - y (y inverted per bit, carry-in = sub)
//   s    : N-bit result; the final carry-out is not produced
module rca_addsub #(
  parameter int N = 9
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         sub,
  output logic [N-1:0] s
);

  logic [N-1:0] w_y;
  logic [N-1:0] w_c;

  assign w_c[0] = sub;

  genvar i;
  for (i = 0; i < N; i++) begin : g_fa
    assign w_y[i] = y[i] ^ sub;
    assign s[i]   = x[i] ^ w_y[i] ^ w_c[i];
    // The top cell's carry-out is discarded, so no carry is built for it.
    if (i < N - 1) begin : g_carry
      assign w_c[i+1] = (x[i] & w_y[i]) | (w_c[i] & (x[i] ^ w_y[i]));
    end
  end

endmodule

// File: rtl/booth_seq_mult_ctrl.sv
// booth_seq_mult_ctrl: sequencer for a radix-2 Booth signed multiplier that
// reuses one (W+1)-bit ripple add/sub over W clock cycles.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (aborts an operation in flight)
//   bus   : slave side of booth_seq_mult_ctrl_if (start/a/b in,
//           busy/done/product out)
// Latency: start accepted at edge N -> done high in the cycle after edge N+W.
module booth_seq_mult_ctrl
  import booth_seq_mult_ctrl_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  booth_seq_mult_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(W) + 1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [W:0]       r_a;
  logic [W:0]       r_m;
  logic [W-1:0]     r_q;
  logic             r_q_1;
  logic [CNT_W-1:0] r_count;
  logic [2*W-1:0]   r_product;

  booth_op_t        w_op;
  logic             w_sub;
  logic [W:0]       w_sum;
  logic [W:0]       w_a_new;
  logic             w_last;
  logic             w_accept;
  logic             w_busy;
  logic             w_done;

  assign w_op     = booth_decode(r_q[0], r_q_1);
  assign w_sub    = (w_op == OP_SUB);
  assign w_a_new  = (w_op == OP_NOP) ? r_a : w_sum;
  assign w_last   = (r_count == CNT_W'(W - 1));
  assign w_accept = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  rca_addsub #(.N(W + 1)) u_addsub (
    .x   (r_a),
    .y   (r_m),
    .sub (w_sub),
    .s   (w_sum)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = ST_CALC;
        else          w_state_nxt = ST_IDLE;
      end
      ST_CALC: begin
        if (w_last) w_state_nxt = ST_DONE;
        else        w_state_nxt = ST_CALC;
      end
      ST_DONE: begin
        if (w_accept) w_state_nxt = ST_CALC;
        else          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs, decoded from the registered state.
  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      ST_CALC: w_busy = 1'b1;
      ST_DONE: w_done = 1'b1;
      default: begin
        w_busy = 1'b0;
        w_done = 1'b0;
      end
    endcase
  end

  assign bus.busy    = w_busy;
  assign bus.done    = w_done;
  assign bus.product = r_product;

  // Booth datapath registers: operand load, one step per CALC cycle, and
  // product capture on the final step (the edge that enters DONE).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_m       <= '0;
      r_q       <= '0;
      r_q_1     <= 1'b0;
      r_count   <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            r_a     <= '0;
            r_m     <= {bus.a[W-1], bus.a};
            r_q     <= bus.b;
            r_q_1   <= 1'b0;
            r_count <= '0;
          end
        end
        ST_CALC: begin
          // Arithmetic shift right of {A, Q, q_1} after the add/sub.
          r_a     <= {w_a_new[W], w_a_new[W:1]};
          r_q     <= {w_a_new[0], r_q[W-1:1]};
          r_q_1   <= r_q[0];
          r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
          // Post-shift {A[W-1:0], Q} equals {w_a_new, Q[W-1:1]}.
          if (w_last) begin
            r_product <= {w_a_new, r_q[W-1:1]};
          end
        end
        default: begin
          r_a <= r_a;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_mult_ctrl.sv
// Self-checking bench for booth_seq_mult_ctrl (W=8). Expected products are
// pushed to a scoreboard queue when an operation is started and popped when
// done pulses.
module tb_booth_seq_mult_ctrl;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  booth_seq_mult_ctrl_if #(.W(W)) bus ();

  booth_seq_mult_ctrl #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [2*W-1:0] sb_q[$];

  // Present an operation at a negedge and record its expected product.
  task automatic drive_start(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                             input logic [2*W-1:0] exp);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = ta;
    bus.b     = tb_v;
    sb_q.push_back(exp);
  endtask

  // Count edges from acceptance until done is seen (bounded).
  task automatic wait_done(input bit drop_start, output int cyc, output bit timeout);
    cyc = 0;
    timeout = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      cyc++;
      if (drop_start && cyc == 1) begin
        #1 bus.start = 1'b0;
      end
      @(negedge clk);
      if (bus.done) begin
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b product=%h, required 0 0 0000",
               bus.busy, bus.done, bus.product);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    logic [W-1:0]   va [6] = '{8'd3, 8'hFD, 8'd127, 8'h80, 8'd0, 8'h80};
    logic [W-1:0]   vb [6] = '{8'd5, 8'd5, 8'h80, 8'h80, 8'hFF, 8'd127};
    logic [2*W-1:0] vp [6] = '{16'h000F, 16'hFFF1, 16'hC080, 16'h4000, 16'h0000, 16'hC080};
    int cyc;
    bit to;
    logic [2*W-1:0] exp;
    for (int k = 0; k < 6; k++) begin
      drive_start(va[k], vb[k], vp[k]);
      wait_done(1'b1, cyc, to);
      checks++;
      if (to || cyc != W + 1) begin
        errors++;
        $display("FAIL vec%0d_latency: got %0d cycles (timeout=%0d), required %0d", k, cyc, to, W + 1);
      end
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL vec%0d_scoreboard: queue empty at done", k);
      end else begin
        exp = sb_q.pop_front();
        checks++;
        if (bus.product !== exp) begin
          errors++;
          $display("FAIL vec%0d_product: got %h, required %h", k, bus.product, exp);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic signed [W-1:0]   ra;
    logic signed [W-1:0]   rb;
    logic signed [2*W-1:0] p;
    logic [2*W-1:0] exp;
    int cyc;
    bit to;
    for (int k = 0; k < 6; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      p  = ra * rb;
      drive_start(ra, rb, p);
      wait_done(1'b1, cyc, to);
      if (to || sb_q.size() == 0) begin
        errors++;
        $display("FAIL rand%0d_done: timeout=%0d queue=%0d", k, to, sb_q.size());
      end else begin
        exp = sb_q.pop_front();
        checks++;
        if (bus.product !== exp) begin
          errors++;
          $display("FAIL rand%0d_product: a=%0d b=%0d got %h, required %h", k, ra, rb, bus.product, exp);
        end
      end
    end
  endtask

  task automatic test_ignore_start();
    int cyc;
    bit to;
    logic [2*W-1:0] exp;
    drive_start(8'd3, 8'd5, 16'h000F);
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 8'd7;
    bus.b = 8'd9;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL ignore_busy: got %b, required 1", bus.busy);
    end
    wait_done(1'b0, cyc, to);
    if (to || sb_q.size() == 0) begin
      errors++;
      $display("FAIL ignore_done: timeout=%0d queue=%0d", to, sb_q.size());
    end else begin
      exp = sb_q.pop_front();
      checks++;
      if (bus.product !== exp) begin
        errors++;
        $display("FAIL ignore_product: got %h, required %h", bus.product, exp);
      end
    end
    cyc = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done || bus.busy) cyc++;
    end
    checks++;
    if (cyc != 0) begin
      errors++;
      $display("FAIL ignore_extra_op: %0d active cycles after done, required 0", cyc);
    end
  endtask

  task automatic test_reset_mid_calc();
    int cyc;
    bit to;
    logic [2*W-1:0] exp;
    drive_start(8'd100, 8'd77, 16'h0000);
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 16'h0000) begin
      errors++;
      $display("FAIL midreset_state: busy=%b done=%b product=%h, required 0 0 0000",
               bus.busy, bus.done, bus.product);
    end
    void'(sb_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done) cyc++;
    end
    checks++;
    if (cyc != 0) begin
      errors++;
      $display("FAIL midreset_no_done: %0d done pulses, required 0", cyc);
    end
    drive_start(8'hF9, 8'd6, 16'hFFD6);
    wait_done(1'b1, cyc, to);
    if (to || sb_q.size() == 0) begin
      errors++;
      $display("FAIL midreset_next_done: timeout=%0d queue=%0d", to, sb_q.size());
    end else begin
      exp = sb_q.pop_front();
      checks++;
      if (bus.product !== exp || cyc != W + 1) begin
        errors++;
        $display("FAIL midreset_next_op: got %h in %0d cycles, required %h in %0d",
                 bus.product, cyc, exp, W + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit to;
    logic [2*W-1:0] exp;
    drive_start(8'd3, 8'd5, 16'h000F);
    wait_done(1'b0, cyc, to);
    if (to || sb_q.size() == 0) begin
      errors++;
      $display("FAIL b2b_first_done: timeout=%0d queue=%0d", to, sb_q.size());
    end else begin
      exp = sb_q.pop_front();
      checks++;
      if (bus.product !== exp) begin
        errors++;
        $display("FAIL b2b_first_product: got %h, required %h", bus.product, exp);
      end
    end
    // start still high: new operands are taken at the DONE edge.
    bus.a = 8'hFD;
    bus.b = 8'd5;
    sb_q.push_back(16'hFFF1);
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.product !== 16'h000F) begin
      errors++;
      $display("FAIL b2b_restart: busy=%b done=%b product=%h, required 1 0 000F",
               bus.busy, bus.done, bus.product);
    end
    cyc = 1;
    to = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) begin
        to = 1'b0;
        break;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    if (to || sb_q.size() == 0) begin
      errors++;
      $display("FAIL b2b_second_done: timeout=%0d queue=%0d", to, sb_q.size());
    end else begin
      exp = sb_q.pop_front();
      checks++;
      if (bus.product !== exp || cyc != W + 1) begin
        errors++;
        $display("FAIL b2b_second: got %h after %0d cycles, required %h after %0d",
                 bus.product, cyc, exp, W + 1);
      end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    test_reset();
    test_vectors();
    test_random();
    test_ignore_start();
    test_reset_mid_calc();
    test_back_to_back();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
